// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmitter slice.
package uart_pkg;

  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_CLKS_PER_BIT = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_tx_baud_gen #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic clk_32,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Restarting on bit_done keeps every bit exactly CLKS_PER_BIT cycles long.
  always_ff @(posedge clk_32 or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || bit_done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk_32,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg;
  logic                  par_type_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      next_idx;
  logic                  parity_bit;
  logic                  bit_done;
  logic                  baud_clear;

  assign tx_ready   = (state == ST_IDLE);
  assign busy       = ~tx_ready;
  assign baud_clear = tx_ready;
  assign next_idx   = bit_idx + 1'b1;
  assign parity_bit = (^data_reg) ^ par_type_reg;

  uart_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_32  (clk_32),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  // tx_out is registered and updated one cycle ahead of the bit it belongs to.
  always_ff @(posedge clk_32 or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      bit_idx      <= '0;
      tx_out       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            data_reg     <= tx_data;
            par_en_reg   <= par_en;
            par_type_reg <= par_type;
            bit_idx      <= '0;
            tx_out       <= 1'b0;
            state        <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            tx_out  <= data_reg[0];
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_reg) begin
                tx_out <= parity_bit;
                state  <= ST_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= ST_STOP;
              end
            end else begin
              bit_idx <= next_idx;
              tx_out  <= data_reg[next_idx];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            tx_out <= 1'b1;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_out <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus back-to-back, mid-frame poke, reset and fast-baud cases.
module tb_uart_tx;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    string      bits;
  } vec_t;

  logic       clk_32 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_type = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;

  logic [7:0] tx_data_f = '0;
  logic       tx_valid_f = 1'b0;
  logic       par_en_f = 1'b0;
  logic       par_type_f = 1'b0;
  logic       tx_ready_f;
  logic       tx_out_f;
  logic       busy_f;

  int checks = 0;
  int errors = 0;

  vec_t vecs [6];

  always #5 clk_32 = ~clk_32;

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(32)) dut (
    .clk_32  (clk_32),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .par_en  (par_en),
    .par_type(par_type),
    .tx_out  (tx_out),
    .busy    (busy)
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) dut_fast (
    .clk_32  (clk_32),
    .rst     (rst),
    .tx_data (tx_data_f),
    .tx_valid(tx_valid_f),
    .tx_ready(tx_ready_f),
    .par_en  (par_en_f),
    .par_type(par_type_f),
    .tx_out  (tx_out_f),
    .busy    (busy_f)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) for ready at a negedge, offer the byte, return at the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] data, input bit pe, input bit pt, input bit fast);
    int waited = 0;
    while (!(fast ? tx_ready_f : tx_ready) && waited < 2000) begin
      @(negedge clk_32);
      waited++;
    end
    checkOutput("ready before offer", {31'd0, fast ? tx_ready_f : tx_ready}, 32'd1);
    if (fast) begin
      tx_data_f = data; par_en_f = pe; par_type_f = pt; tx_valid_f = 1'b1;
    end else begin
      tx_data = data; par_en = pe; par_type = pt; tx_valid = 1'b1;
    end
    @(posedge clk_32);
    @(negedge clk_32);
  endtask

  // Sample every cycle of the frame against the hand-written bit pattern, then check the idle cycle.
  task automatic checkFrame(input string name, input string pattern, input int clks, input bit fast, input int poke_bit);
    int  err;
    logic expected;
    for (int i = 0; i < pattern.len(); i++) begin
      err = 0;
      expected = (pattern.getc(i) == 8'h31);
      for (int c = 0; c < clks; c++) begin
        if ((fast ? tx_out_f : tx_out) !== expected) err++;
        if ((fast ? busy_f : busy) !== 1'b1) err++;
        if ((fast ? tx_ready_f : tx_ready) !== 1'b0) err++;
        if (poke_bit == i && c == 1) begin
          tx_data = 8'hFF;
          tx_valid = 1'b1;
        end
        if (poke_bit == i && c == 3) tx_valid = 1'b0;
        @(negedge clk_32);
      end
      checkOutput($sformatf("%s bit%0d", name, i), err, 0);
    end
    checkOutput({name, " ready at end"}, {31'd0, fast ? tx_ready_f : tx_ready}, 32'd1);
    checkOutput({name, " busy at end"}, {31'd0, fast ? busy_f : busy}, 32'd0);
    checkOutput({name, " idle line"}, {31'd0, fast ? tx_out_f : tx_out}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, "0101001011"};
    vecs[1] = '{8'h07, 1'b1, 1'b0, "01110000011"};
    vecs[2] = '{8'h07, 1'b1, 1'b1, "01110000001"};
    vecs[3] = '{8'h00, 1'b1, 1'b0, "00000000001"};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, "01111111111"};
    vecs[5] = '{8'hC3, 1'b0, 1'b0, "0110000111"};

    repeat (3) @(negedge clk_32);
    checkOutput("reset tx_out", {31'd0, tx_out}, 32'd1);
    checkOutput("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset fast tx_out", {31'd0, tx_out_f}, 32'd1);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].data, vecs[v].pe, vecs[v].pt, 1'b0);
      tx_valid = 1'b0;
      tx_data  = ~vecs[v].data;
      par_en   = ~vecs[v].pe;
      par_type = ~vecs[v].pt;
      checkFrame($sformatf("vec%0d", v), vecs[v].bits, 32, 1'b0, -1);
    end

    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    tx_data = 8'hAA;
    checkFrame("b2b 55", "0101010101", 32, 1'b0, -1);
    @(posedge clk_32);
    @(negedge clk_32);
    tx_valid = 1'b0;
    checkFrame("b2b aa", "0010101011", 32, 1'b0, -1);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    tx_valid = 1'b0;
    checkFrame("poke 3c", "0001111001", 32, 1'b0, 3);
    begin
      int err = 0;
      for (int c = 0; c < 5; c++) begin
        if (tx_out !== 1'b1 || tx_ready !== 1'b1) err++;
        @(negedge clk_32);
      end
      checkOutput("no queued frame", err, 0);
    end

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tx_valid = 1'b0;
    repeat (138) @(negedge clk_32);
    checkOutput("mid data bit3 line", {31'd0, tx_out}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("async rst tx_out", {31'd0, tx_out}, 32'd1);
    checkOutput("async rst tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("async rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk_32);
    rst = 1'b0;
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0);
    tx_valid = 1'b0;
    checkFrame("after rst 81", "0100000011", 32, 1'b0, -1);

    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1);
    tx_valid_f = 1'b0;
    tx_data_f  = 8'h0F;
    checkFrame("fast f0", "0000011111", 2, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 32, clk_32 cycles per bit period. Legal range is 2 to 1024.
REQ-003 Port clk_32, input, 1, sole clock; the 32x bit-rate clock.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port tx_data, input, DATA_WIDTH, byte to transmit.
REQ-006 Port tx_valid, input, 1, tx_data is offered.
REQ-007 Port tx_ready, output, 1, block can accept a byte this cycle.
REQ-008 Port par_en, input, 1, enables the parity bit.
REQ-009 Port par_type, input, 1, parity sense: 0 = even, 1 = odd.
REQ-010 Port tx_out, output, 1, serial line; idle level is 1.
REQ-011 Port busy, output, 1, a frame is in progress.

Function
REQ-012 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-013 Acceptance SHALL occur on a rising clk_32 edge where tx_valid=1 and tx_ready=1. tx_ready SHALL be 1 exactly when the state is IDLE.
REQ-014 On acceptance, the block SHALL register tx_data, par_en and par_type. Later changes to these inputs SHALL NOT affect the frame in flight.
REQ-015 The FSM SHALL go IDLE->START on acceptance. tx_out SHALL go 0 on the cycle following the acceptance edge, with tx_out registered (no combinational path).
REQ-016 Each of start, data, parity and stop bits SHALL hold tx_out constant for exactly CLKS_PER_BIT cycles.
REQ-017 Data bits SHALL be sent LSB first, using a bit index counter from 0 to DATA_WIDTH-1.
REQ-018 After the last data bit, the FSM SHALL go to PARITY if the latched par_en=1, otherwise directly to STOP.
REQ-019 The parity bit SHALL be the XOR of the latched data when par_type=0, and the inverted XOR when par_type=1.
REQ-020 STOP SHALL drive tx_out=1 for one bit period, then go to IDLE.
REQ-021 Frame length SHALL be (DATA_WIDTH+2+par_en)*CLKS_PER_BIT cycles, measured from the first 0 on tx_out to re-entry into IDLE.
REQ-022 When tx_valid is held high continuously, consecutive frames SHALL be separated by exactly 1 idle cycle (the IDLE acceptance cycle), during which tx_out=1.
REQ-023 tx_valid asserted outside IDLE SHALL be ignored, with no queueing.
REQ-024 busy SHALL equal NOT tx_ready.
REQ-025 The bit-period counter SHALL clear on acceptance and at each bit boundary. It SHALL count 0..CLKS_PER_BIT-1 and never wrap mid-bit.

Reset
REQ-026 While rst=1, the outputs SHALL be: tx_out=1, tx_ready=1, busy=0, state IDLE, all counters and data registers 0.
REQ-027 rst asserted mid-frame SHALL immediately (asynchronously) abandon the frame and force tx_out=1.
REQ-028 The first acceptance after rst deasserts SHALL be possible on the first clk_32 edge.

Structure
REQ-029 Package uart_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, PARITY, STOP) and the default constants UART_DATA_WIDTH=8 and UART_CLKS_PER_BIT=32.
REQ-030 Sub-module uart_tx_baud_gen SHALL hold the bit-period counter. It SHALL take a clear input and produce a one-cycle bit_done pulse on count CLKS_PER_BIT-1.
REQ-031 The FSM, shift register, bit index and parity logic SHALL reside in uart_tx.

Verification
REQ-032 Send 0xA5 with par_en=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held for 32 cycles; tx_ready returns to 1 after 320 cycles.
REQ-033 Send 0x07 with par_en=1, par_type=0 -> parity bit 1. Repeat with par_type=1 -> parity bit 0. Frame is 352 cycles.
REQ-034 Hold tx_valid=1 with 0x55 then 0xAA -> two frames separated by exactly 1 idle cycle of tx_out=1; second frame's data is 0xAA.
REQ-035 Accept 0x3C, then change tx_data to 0xFF and pulse tx_valid during DATA -> transmitted bits remain 0x3C; no second frame starts.
REQ-036 Assert rst during data bit 3 of 0x00 -> tx_out=1 and tx_ready=1 before the next clock edge. After release, 0x81 transmits correctly.
REQ-037 Run with CLKS_PER_BIT=2 and 0xF0 -> every bit lasts exactly 2 cycles and the frame is 20 cycles.
